// File: rtl/traffic_phase_scheduler.sv
// Demand-driven 4-road junction phase sequencer, timed in external ticks.
// Optional pedestrian all-red phase is enabled by defining PED_ALLRED_EN.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_T   = 20,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned YELLOW_T  = 5,
  parameter int unsigned PED_T     = 10,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  sensor,
`ifdef PED_ALLRED_EN
  input  logic        ped_req,
  output logic        ped_walk,
`endif
  output logic [11:0] light,
  output logic [1:0]  active_road,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    PH_RED_CLEAR = 2'd0,
    PH_GREEN     = 2'd1,
    PH_YELLOW    = 2'd2,
    PH_PED       = 2'd3
  } phase_e;

  localparam logic [CNT_W:0] GREEN_LIM  = (CNT_W+1)'(GREEN_T);
  localparam logic [CNT_W:0] MIN_LIM    = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0] YELLOW_LIM = (CNT_W+1)'(YELLOW_T);
`ifdef PED_ALLRED_EN
  localparam logic [CNT_W:0] PED_LIM    = (CNT_W+1)'(PED_T);
`endif

  phase_e           phase_q, phase_d;
  logic [1:0]       road_q, road_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      light_q, light_d;
  logic [CNT_W:0]   cnt_p1;
  logic [CNT_W-1:0] cnt_sat;
  logic [1:0]       next_road;
  logic [1:0]       cand;
  logic             found;
  logic             other_req;
`ifdef PED_ALLRED_EN
  logic             ped_pend_q, ped_pend_d;
  logic             ped_walk_q, ped_walk_d;
`endif

  // Round-robin search starting after the current road; the current road
  // itself is the last candidate, so a lone requester keeps being picked.
  always_comb begin
    next_road = road_q + 2'd1;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = road_q + 2'(i);
      if (!found && sensor[cand]) begin
        next_road = cand;
        found     = 1'b1;
      end
    end
  end

  assign other_req = |(sensor & ~(4'b0001 << road_q));
  assign cnt_p1    = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_p1[CNT_W-1:0];

  always_comb begin
    phase_d    = phase_q;
    road_d     = road_q;
    cnt_d      = cnt_q;
`ifdef PED_ALLRED_EN
    ped_pend_d = ped_pend_q | ped_req;
    ped_walk_d = ped_walk_q;
`endif
    if (tick) begin
      unique case (phase_q)
        PH_RED_CLEAR: begin
          cnt_d = '0;
`ifdef PED_ALLRED_EN
          if (ped_pend_q) begin
            phase_d    = PH_PED;
            ped_pend_d = ped_req;
            ped_walk_d = 1'b1;
          end else begin
            road_d  = next_road;
            phase_d = PH_GREEN;
          end
`else
          road_d  = next_road;
          phase_d = PH_GREEN;
`endif
        end
        PH_GREEN: begin
          if (other_req && (cnt_p1 >= GREEN_LIM ||
                            (cnt_p1 >= MIN_LIM && !sensor[road_q]))) begin
            phase_d = PH_YELLOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        PH_YELLOW: begin
          if (cnt_p1 == YELLOW_LIM) begin
            phase_d = PH_RED_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_p1[CNT_W-1:0];
          end
        end
        PH_PED: begin
`ifdef PED_ALLRED_EN
          if (cnt_p1 == PED_LIM) begin
            phase_d    = PH_RED_CLEAR;
            cnt_d      = '0;
            ped_walk_d = 1'b0;
          end else begin
            cnt_d = cnt_p1[CNT_W-1:0];
          end
`else
          phase_d = PH_RED_CLEAR;
          cnt_d   = '0;
`endif
        end
        default: phase_d = PH_RED_CLEAR;
      endcase
    end
  end

  // Lights decoded from the next state so they register on the same edge.
  always_comb begin
    light_d = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (2'(k) == road_d && phase_d == PH_GREEN)
        light_d[3*k +: 3] = 3'b001;
      else if (2'(k) == road_d && phase_d == PH_YELLOW)
        light_d[3*k +: 3] = 3'b010;
      else
        light_d[3*k +: 3] = 3'b100;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= PH_RED_CLEAR;
      road_q     <= 2'd3;
      cnt_q      <= '0;
      light_q    <= 12'h924;
`ifdef PED_ALLRED_EN
      ped_pend_q <= 1'b0;
      ped_walk_q <= 1'b0;
`endif
    end else begin
      phase_q    <= phase_d;
      road_q     <= road_d;
      cnt_q      <= cnt_d;
      light_q    <= light_d;
`ifdef PED_ALLRED_EN
      ped_pend_q <= ped_pend_d;
      ped_walk_q <= ped_walk_d;
`endif
    end
  end

  assign light       = light_q;
  assign active_road = road_q;
  assign phase       = phase_q;
`ifdef PED_ALLRED_EN
  assign ped_walk    = ped_walk_q;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: tick-level reference model checked every
// cycle, plus literal light values for the key scenarios (PED_ALLRED_EN aware).
module tb_traffic_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  sensor = 4'h0;
  logic [11:0] light;
  logic [1:0]  active_road;
  logic [1:0]  phase;
`ifdef PED_ALLRED_EN
  logic        ped_req = 1'b0;
  logic        ped_walk;
`endif

  int checks = 0;
  int failures = 0;

  traffic_phase_scheduler #(
    .GREEN_T(20), .MIN_GREEN(5), .YELLOW_T(5), .PED_T(10), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .sensor(sensor),
`ifdef PED_ALLRED_EN
    .ped_req(ped_req),
    .ped_walk(ped_walk),
`endif
    .light(light),
    .active_road(active_road),
    .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number, served road, ticks spent in the phase.
  int         m_phase;
  logic [1:0] m_road;
  int         m_t;
  bit         m_pend;
  bit         old_pend;
`ifdef PED_ALLRED_EN
  bit         m_walk;
`endif

  function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [3:0] s);
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] r;
      r = cur + 2'(i);
      if (s[r]) return r;
    end
    return cur + 2'd1;
  endfunction

  function automatic logic [11:0] exp_light(input int ph, input logic [1:0] rd);
    logic [11:0] l;
    l = 12'h924;
    if (ph == 1) l[3*rd +: 3] = 3'b001;
    if (ph == 2) l[3*rd +: 3] = 3'b010;
    return l;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_road = 2'd3; m_t = 0; m_pend = 0;
`ifdef PED_ALLRED_EN
      m_walk = 0;
`endif
    end else begin
      old_pend = m_pend;
`ifdef PED_ALLRED_EN
      if (ped_req) m_pend = 1;
`endif
      if (tick) begin
        case (m_phase)
          0: begin
            m_t = 0;
            if (old_pend) begin
              m_phase = 3;
`ifdef PED_ALLRED_EN
              m_pend = ped_req;
              m_walk = 1;
`endif
            end else begin
              m_road  = pick_next(m_road, sensor);
              m_phase = 1;
            end
          end
          1: begin
            m_t = m_t + 1;
            if ((sensor & ~(4'b0001 << m_road)) != 4'h0 &&
                (m_t >= 20 || (m_t >= 5 && !sensor[m_road]))) begin
              m_phase = 2; m_t = 0;
            end else if (m_t > 255) m_t = 255;
          end
          2: begin
            m_t = m_t + 1;
            if (m_t == 5) begin m_phase = 0; m_t = 0; end
          end
          default: begin
            m_t = m_t + 1;
            if (m_t == 10) begin
              m_phase = 0; m_t = 0;
`ifdef PED_ALLRED_EN
              m_walk = 0;
`endif
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("model_light", light, exp_light(m_phase, m_road));
    check("model_phase", phase, m_phase[1:0]);
    check("model_road", active_road, m_road);
`ifdef PED_ALLRED_EN
    check("model_walk", ped_walk, m_walk);
`endif
  end

  task automatic step(input bit t);
    tick = t;
    @(negedge clk);
  endtask

  task automatic steps(input int n, input bit t);
    for (int i = 0; i < n; i++) step(t);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    sensor = 4'hF;
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(i[0]);
    check("rst_light", light, 12'h924);
    check("rst_phase", phase, 2'd0);
    check("rst_road", active_road, 2'd3);

    rst = 1'b1;
    step(1);  check("fd_green0", light, 12'h921);
    steps(19, 1); check("fd_green19", light, 12'h921);
    step(1);  check("fd_yellow", light, 12'h922);
    steps(4, 1); check("fd_yellow4", light, 12'h922);
    step(1);  check("fd_red", light, 12'h924);
    step(1);  check("fd_road1", light, 12'h90C);
    steps(20, 1); check("fd_road1_yel", light, 12'h914);
    steps(2, 1);
    #2 rst = 1'b0;
    #1 check("async_rst_light", light, 12'h924);
    check("async_rst_road", active_road, 2'd3);
    @(negedge clk);
    step(1);  check("rst_tick_ignored", light, 12'h924);

    sensor = 4'b0100;
    rst = 1'b1;
    step(1);  check("skip_road2", light, 12'h864);
    steps(100, 1); check("skip_hold", light, 12'h864);

    do_reset();
    sensor = 4'b1100;
    rst = 1'b1;
    step(1);  check("max_green", light, 12'h864);
    steps(3, 0); check("max_notick", light, 12'h864);
    steps(19, 1); check("max_19", light, 12'h864);
    step(1);  check("max_20", light, 12'h8A4);

    do_reset();
    sensor = 4'b0011;
    rst = 1'b1;
    step(1);  check("gap_green", light, 12'h921);
    steps(2, 1);
    sensor = 4'b0010;
    steps(2, 1); check("gap_4", light, 12'h921);
    step(1);  check("gap_5", light, 12'h922);
    steps(5, 1); check("gap_red", light, 12'h924);
    step(1);  check("gap_next", light, 12'h90C);

`ifdef PED_ALLRED_EN
    do_reset();
    sensor = 4'b0011;
    rst = 1'b1;
    step(1);  check("ped_green", light, 12'h921);
    ped_req = 1'b1;
    step(0);
    ped_req = 1'b0;
    sensor = 4'b0010;
    steps(5, 1); check("ped_yellow", light, 12'h922);
    steps(5, 1); check("ped_red", light, 12'h924);
    step(1);
    check("ped_walk_on", ped_walk, 1'b1);
    check("ped_phase", phase, 2'd3);
    check("ped_light", light, 12'h924);
    steps(9, 1); check("ped_walk_9", ped_walk, 1'b1);
    step(1);
    check("ped_walk_off", ped_walk, 1'b0);
    check("ped_back_red", phase, 2'd0);
    step(1);  check("ped_next_green", light, 12'h90C);
`endif

    tick = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
